// File: rtl/ula_multicycle_ctrl.sv
// ula_multicycle_ctrl: Moore control FSM for the 8-bit multicycle RISC-V core.
// It sequences fetch, decode, execute, memory and writeback. It drives the ULA
// operation, the source/result mux selects and the write enables, and it uses
// the ULA zero flag only to resolve beq.
module ula_multicycle_ctrl (
    input  logic       clk,
    input  logic       reset,
    input  logic [6:0] op,
    input  logic [2:0] funct3,
    input  logic       funct7b5,
    input  logic       Z,
    output logic       PCWrite,
    output logic       AdrSrc,
    output logic       MemWrite,
    output logic       IRWrite,
    output logic       RegWrite,
    output logic [1:0] ResultSrc,
    output logic [1:0] ULASrcA,
    output logic [1:0] ULASrcB,
    output logic [2:0] ULAControl,
    output logic       illegal,
    output logic       retire
);

    // Supported opcodes
    localparam logic [6:0] OP_LW   = 7'b0000011;
    localparam logic [6:0] OP_SW   = 7'b0100011;
    localparam logic [6:0] OP_R    = 7'b0110011;
    localparam logic [6:0] OP_I    = 7'b0010011;
    localparam logic [6:0] OP_BEQ  = 7'b1100011;
    localparam logic [6:0] OP_JAL  = 7'b1101111;

    // ULAControl encoding
    localparam logic [2:0] ULA_AND = 3'b000;
    localparam logic [2:0] ULA_OR  = 3'b001;
    localparam logic [2:0] ULA_ADD = 3'b010;
    localparam logic [2:0] ULA_SUB = 3'b110;
    localparam logic [2:0] ULA_SLT = 3'b111;

    typedef enum logic [3:0] {
        S_FETCH    = 4'd0,
        S_DECODE   = 4'd1,
        S_MEMADR   = 4'd2,
        S_MEMREAD  = 4'd3,
        S_MEMWB    = 4'd4,
        S_MEMWRITE = 4'd5,
        S_EXEC_R   = 4'd6,
        S_EXEC_I   = 4'd7,
        S_ALUWB    = 4'd8,
        S_BEQ      = 4'd9,
        S_JAL      = 4'd10
    } state_e;

    // ALU-op class chosen by the FSM and refined by funct3/funct7b5
    typedef enum logic [1:0] {
        ALUOP_ADD   = 2'b00,
        ALUOP_SUB   = 2'b01,
        ALUOP_FUNCT = 2'b10
    } alu_op_e;

    state_e  state_q, state_d;
    alu_op_e alu_op;
    logic    op_is_r;
    logic    op_is_i;
    logic    op_known;
    logic    funct3_ok;

    // Instruction classification from the held IR fields
    always_comb begin
        op_is_r   = (op == OP_R);
        op_is_i   = (op == OP_I);
        op_known  = (op == OP_LW) || (op == OP_SW) || op_is_r || op_is_i ||
                    (op == OP_BEQ) || (op == OP_JAL);
        funct3_ok = (funct3 == 3'b000) || (funct3 == 3'b010) ||
                    (funct3 == 3'b110) || (funct3 == 3'b111);
    end

    // State register; reset always returns to FETCH
    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignment so every flop
        // samples pre-edge values regardless of block evaluation order.
        if (reset) state_q <= S_FETCH;
        else       state_q <= state_d;
    end

    // Next-state and Moore outputs; reset masks all enables and shows FETCH selects
    always_comb begin
        // NOTE: every output and state_d gets a default first so no path
        // through the case leaves a signal unassigned and infers a latch.
        state_d   = S_FETCH;
        PCWrite   = 1'b0;
        AdrSrc    = 1'b0;
        MemWrite  = 1'b0;
        IRWrite   = 1'b0;
        RegWrite  = 1'b0;
        ResultSrc = 2'b00;
        ULASrcA   = 2'b00;
        ULASrcB   = 2'b00;
        alu_op    = ALUOP_ADD;
        illegal   = 1'b0;
        retire    = 1'b0;

        case (state_q)
            S_FETCH: begin
                IRWrite   = 1'b1;
                PCWrite   = 1'b1;
                ULASrcB   = 2'b10;
                ResultSrc = 2'b10;
                state_d   = S_DECODE;
            end
            S_DECODE: begin
                ULASrcA = 2'b01;
                ULASrcB = 2'b01;
                if (!op_known || ((op_is_r || op_is_i) && !funct3_ok)) begin
                    illegal = 1'b1;
                    state_d = S_FETCH;
                end else if (op == OP_LW || op == OP_SW) begin
                    state_d = S_MEMADR;
                end else if (op_is_r) begin
                    state_d = S_EXEC_R;
                end else if (op_is_i) begin
                    state_d = S_EXEC_I;
                end else if (op == OP_BEQ) begin
                    state_d = S_BEQ;
                end else begin
                    state_d = S_JAL;
                end
            end
            S_MEMADR: begin
                ULASrcA = 2'b10;
                ULASrcB = 2'b01;
                state_d = (op == OP_SW) ? S_MEMWRITE : S_MEMREAD;
            end
            S_MEMREAD: begin
                AdrSrc  = 1'b1;
                state_d = S_MEMWB;
            end
            S_MEMWB: begin
                ResultSrc = 2'b01;
                RegWrite  = 1'b1;
                retire    = 1'b1;
            end
            S_MEMWRITE: begin
                AdrSrc   = 1'b1;
                MemWrite = 1'b1;
                retire   = 1'b1;
            end
            S_EXEC_R: begin
                ULASrcA = 2'b10;
                alu_op  = ALUOP_FUNCT;
                state_d = S_ALUWB;
            end
            S_EXEC_I: begin
                ULASrcA = 2'b10;
                ULASrcB = 2'b01;
                alu_op  = ALUOP_FUNCT;
                state_d = S_ALUWB;
            end
            S_ALUWB: begin
                RegWrite = 1'b1;
                retire   = 1'b1;
            end
            S_BEQ: begin
                ULASrcA = 2'b10;
                alu_op  = ALUOP_SUB;
                PCWrite = Z;
                retire  = 1'b1;
            end
            S_JAL: begin
                ULASrcA = 2'b01;
                ULASrcB = 2'b10;
                PCWrite = 1'b1;
                state_d = S_ALUWB;
            end
            default: begin
                state_d = S_FETCH;
            end
        endcase

        if (reset) begin
            PCWrite   = 1'b0;
            MemWrite  = 1'b0;
            IRWrite   = 1'b0;
            RegWrite  = 1'b0;
            illegal   = 1'b0;
            retire    = 1'b0;
            AdrSrc    = 1'b0;
            ResultSrc = 2'b10;
            ULASrcA   = 2'b00;
            ULASrcB   = 2'b10;
            alu_op    = ALUOP_ADD;
        end
    end

    // ULA operation decode from the ALU-op class and funct fields
    always_comb begin
        ULAControl = ULA_ADD;
        case (alu_op)
            ALUOP_SUB: ULAControl = ULA_SUB;
            ALUOP_FUNCT: begin
                case (funct3)
                    3'b000:  ULAControl = (op_is_r && funct7b5) ? ULA_SUB : ULA_ADD;
                    3'b010:  ULAControl = ULA_SLT;
                    3'b110:  ULAControl = ULA_OR;
                    3'b111:  ULAControl = ULA_AND;
                    default: ULAControl = ULA_ADD;
                endcase
            end
            default: ULAControl = ULA_ADD;
        endcase
    end

endmodule

// File: tb/tb_ula_multicycle_ctrl.sv
// tb_ula_multicycle_ctrl: scoreboard bench for the multicycle control FSM.
// Stimulus expands each instruction into its expected per-cycle output trace
// from the instruction class and pushes one record per cycle; a negedge monitor
// pops and compares whatever the DUT presents in that cycle.
module tb_ula_multicycle_ctrl;

    localparam logic [6:0] OP_LW  = 7'b0000011;
    localparam logic [6:0] OP_SW  = 7'b0100011;
    localparam logic [6:0] OP_R   = 7'b0110011;
    localparam logic [6:0] OP_I   = 7'b0010011;
    localparam logic [6:0] OP_BEQ = 7'b1100011;
    localparam logic [6:0] OP_JAL = 7'b1101111;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic [6:0] op = 7'd0;
    logic [2:0] funct3 = 3'd0;
    logic       funct7b5 = 1'b0;
    logic       Z = 1'b0;
    logic       PCWrite, AdrSrc, MemWrite, IRWrite, RegWrite, illegal, retire;
    logic [1:0] ResultSrc, ULASrcA, ULASrcB;
    logic [2:0] ULAControl;

    ula_multicycle_ctrl dut (
        .clk        (clk),
        .reset      (reset),
        .op         (op),
        .funct3     (funct3),
        .funct7b5   (funct7b5),
        .Z          (Z),
        .PCWrite    (PCWrite),
        .AdrSrc     (AdrSrc),
        .MemWrite   (MemWrite),
        .IRWrite    (IRWrite),
        .RegWrite   (RegWrite),
        .ResultSrc  (ResultSrc),
        .ULASrcA    (ULASrcA),
        .ULASrcB    (ULASrcB),
        .ULAControl (ULAControl),
        .illegal    (illegal),
        .retire     (retire)
    );

    always #5 clk = ~clk;

    // Packed view: [15]PCWrite [14]AdrSrc [13]MemWrite [12]IRWrite [11]RegWrite
    // [10:9]ResultSrc [8:7]ULASrcA [6:5]ULASrcB [4:2]ULAControl [1]illegal [0]retire
    typedef struct {
        logic [15:0] val;
        logic [15:0] care;
        string       tag;
        logic        z_fixed;
        logic        z_val;
    } exp_t;

    exp_t sb_q[$];
    exp_t plan_q[$];
    int   checks = 0;
    int   failures = 0;

    logic [15:0] act;
    assign act = {PCWrite, AdrSrc, MemWrite, IRWrite, RegWrite, ResultSrc,
                  ULASrcA, ULASrcB, ULAControl, illegal, retire};

    function automatic exp_t mk(input string tag, input logic pcw, input logic adr,
                                input logic memw, input logic irw, input logic regw,
                                input logic [1:0] rs, input logic [1:0] sa,
                                input logic [1:0] sb, input logic [2:0] uc,
                                input logic uc_care, input logic ill, input logic ret);
        exp_t e;
        e.val     = {pcw, adr, memw, irw, regw, rs, sa, sb, uc, ill, ret};
        e.care    = uc_care ? 16'hFFFF : 16'hFFE3;
        e.tag     = tag;
        e.z_fixed = 1'b0;
        e.z_val   = 1'b0;
        return e;
    endfunction

    // Reference ULA operation for ALU-class instructions
    function automatic logic [2:0] ref_ula(input logic [6:0] o, input logic [2:0] f3,
                                           input logic f7);
        case (f3)
            3'b000:  return (o == OP_R && f7) ? 3'b110 : 3'b010;
            3'b010:  return 3'b111;
            3'b110:  return 3'b001;
            3'b111:  return 3'b000;
            default: return 3'b010;
        endcase
    endfunction

    function automatic logic ref_legal(input logic [6:0] o, input logic [2:0] f3);
        logic f3_ok;
        f3_ok = (f3 == 3'b000) || (f3 == 3'b010) || (f3 == 3'b110) || (f3 == 3'b111);
        if (o == OP_R || o == OP_I) return f3_ok;
        return (o == OP_LW) || (o == OP_SW) || (o == OP_BEQ) || (o == OP_JAL);
    endfunction

    // Expected trace of one instruction, one record per clock cycle
    function automatic void plan_instr(input logic [6:0] o, input logic [2:0] f3,
                                       input logic f7, input logic z);
        exp_t e;
        logic legal;
        legal = ref_legal(o, f3);
        plan_q.push_back(mk("fetch", 1, 0, 0, 1, 0, 2'b10, 2'b00, 2'b10, 3'b010, 1, 0, 0));
        plan_q.push_back(mk("decode", 0, 0, 0, 0, 0, 2'b00, 2'b01, 2'b01, 3'b010, 1, !legal, 0));
        if (!legal) return;
        if (o == OP_LW || o == OP_SW)
            plan_q.push_back(mk("memadr", 0, 0, 0, 0, 0, 2'b00, 2'b10, 2'b01, 3'b010, 1, 0, 0));
        if (o == OP_LW) begin
            plan_q.push_back(mk("memread", 0, 1, 0, 0, 0, 2'b00, 2'b00, 2'b00, 3'b000, 0, 0, 0));
            plan_q.push_back(mk("memwb", 0, 0, 0, 0, 1, 2'b01, 2'b00, 2'b00, 3'b000, 0, 0, 1));
        end else if (o == OP_SW) begin
            plan_q.push_back(mk("memwrite", 0, 1, 1, 0, 0, 2'b00, 2'b00, 2'b00, 3'b000, 0, 0, 1));
        end else if (o == OP_BEQ) begin
            e = mk("beq", z, 0, 0, 0, 0, 2'b00, 2'b10, 2'b00, 3'b110, 1, 0, 1);
            e.z_fixed = 1'b1;
            e.z_val   = z;
            plan_q.push_back(e);
        end else begin
            if (o == OP_R)
                plan_q.push_back(mk("exec_r", 0, 0, 0, 0, 0, 2'b00, 2'b10, 2'b00,
                                    ref_ula(o, f3, f7), 1, 0, 0));
            else if (o == OP_I)
                plan_q.push_back(mk("exec_i", 0, 0, 0, 0, 0, 2'b00, 2'b10, 2'b01,
                                    ref_ula(o, f3, f7), 1, 0, 0));
            else
                plan_q.push_back(mk("jal", 1, 0, 0, 0, 0, 2'b00, 2'b01, 2'b10, 3'b010, 1, 0, 0));
            plan_q.push_back(mk("aluwb", 0, 0, 0, 0, 1, 2'b00, 2'b00, 2'b00, 3'b000, 0, 0, 1));
        end
    endfunction

    // Drive one instruction for up to max_cycles of its trace
    task automatic run_instr(input logic [6:0] o, input logic [2:0] f3, input logic f7,
                             input logic z, input int max_cycles = 100);
        exp_t e;
        int   n;
        plan_q.delete();
        plan_instr(o, f3, f7, z);
        n = 0;
        while (plan_q.size() != 0 && n < max_cycles) begin
            e = plan_q.pop_front();
            @(posedge clk);
            #1;
            reset    = 1'b0;
            op       = o;
            funct3   = f3;
            funct7b5 = f7;
            Z        = e.z_fixed ? e.z_val : 1'($urandom);
            sb_q.push_back(e);
            n++;
        end
    endtask

    // Hold reset for n cycles; enables must be quiet, selects show FETCH values
    task automatic do_reset(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
            reset = 1'b1;
            Z     = 1'($urandom);
            sb_q.push_back(mk("reset", 0, 0, 0, 0, 0, 2'b10, 2'b00, 2'b10, 3'b010, 1, 0, 0));
        end
    endtask

    // Monitor: compare the DUT against the record for this cycle
    always @(negedge clk) begin
        exp_t e;
        if (sb_q.size() != 0) begin
            e = sb_q.pop_front();
            checks++;
            if ((act & e.care) !== (e.val & e.care)) begin
                failures++;
                $display("FAIL %s @%0t: got %h expected %h (care %h)",
                         e.tag, $time, act, e.val, e.care);
            end
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [6:0] ops [7];
        logic [6:0] o;
        ops[0] = OP_LW; ops[1] = OP_SW; ops[2] = OP_R; ops[3] = OP_I;
        ops[4] = OP_BEQ; ops[5] = OP_JAL; ops[6] = 7'b1111111;

        do_reset(3);

        run_instr(OP_R, 3'b000, 1'b0, 1'b0);
        run_instr(OP_R, 3'b000, 1'b1, 1'b0);
        run_instr(OP_LW, 3'b010, 1'b0, 1'b0);
        run_instr(OP_SW, 3'b010, 1'b0, 1'b1);
        run_instr(OP_BEQ, 3'b000, 1'b0, 1'b1);
        run_instr(OP_BEQ, 3'b000, 1'b0, 1'b0);
        run_instr(OP_I, 3'b010, 1'b0, 1'b0);
        run_instr(OP_I, 3'b110, 1'b1, 1'b0);
        run_instr(OP_I, 3'b111, 1'b0, 1'b0);
        run_instr(OP_I, 3'b000, 1'b1, 1'b0);
        run_instr(OP_I, 3'b001, 1'b0, 1'b0);
        run_instr(OP_R, 3'b100, 1'b0, 1'b0);
        run_instr(7'b1111111, 3'b000, 1'b0, 1'b0);
        run_instr(OP_JAL, 3'b000, 1'b0, 1'b1);

        // lw interrupted by reset while in MEMADR, then a fresh instruction
        run_instr(OP_LW, 3'b010, 1'b0, 1'b0, 2);
        do_reset(3);
        run_instr(OP_R, 3'b110, 1'b0, 1'b0);

        for (int i = 0; i < 120; i++) begin
            o = ops[$urandom_range(0, 6)];
            if ($urandom_range(0, 9) == 0) o = 7'($urandom);
            run_instr(o, 3'($urandom), 1'($urandom), 1'($urandom));
        end

        @(negedge clk);
        #1;
        checks++;
        if (sb_q.size() != 0) begin
            failures++;
            $display("FAIL drain: %0d records left, expected 0", sb_q.size());
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
